// File: rtl/sram_bus_ctrl_pkg.sv
// Shared definitions for the SRAM cycle engine: IO register map, CTRL/STATUS
// bit positions and the access-sequencer state encoding.
package sram_bus_ctrl_pkg;

  localparam logic [1:0] REG_ADDR_LO = 2'd0;
  localparam logic [1:0] REG_ADDR_HI = 2'd1;
  localparam logic [1:0] REG_DATA    = 2'd2;
  localparam logic [1:0] REG_CTRL    = 2'd3;

  localparam int CTRL_AUTOINC_BIT = 0;
  localparam int CTRL_READ_BIT    = 1;
  localparam int CTRL_CLRERR_BIT  = 3;

  localparam int STAT_BUSY_BIT    = 0;
  localparam int STAT_RVALID_BIT  = 1;
  localparam int STAT_AUTOINC_BIT = 2;
  localparam int STAT_ERR_BIT     = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_W_SETUP,
    S_W_PULSE,
    S_W_HOLD,
    S_R_PULSE,
    S_R_DONE
  } state_e;

endpackage

// File: rtl/sram_bus_ctrl_wait_timer.sv
// Loadable 4-bit down-counter that times the strobe-low phase of an access.
module sram_wait_timer (
  input  logic       pclk,
  input  logic       resetq,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec,
  output logic       done
);

  logic [3:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)
      cnt_d = load_val;
    else if (dec && (cnt_q != 4'd0))
      cnt_d = cnt_q - 4'd1;
  end

  always_ff @(posedge pclk or negedge resetq) begin
    if (!resetq) cnt_q <= 4'd0;
    else         cnt_q <= cnt_d;
  end

  assign done = (cnt_q == 4'd0);

endmodule

// File: rtl/sram_bus_ctrl.sv
// IO-bus mapped SRAM cycle engine: CPU loads address/data, the block sequences
// nCS/nWE/nOE with programmable wait states and optional address auto-increment.
module sram_bus_ctrl
  import sram_bus_ctrl_pkg::*;
#(
  parameter int DW          = 8,
  parameter int AW          = 18,
  parameter int WAIT_CYCLES = 2
) (
  input  logic          pclk,
  input  logic          resetq,
  input  logic [1:0]    io_sel,
  input  logic          io_wr,
  input  logic          io_rd,
  input  logic [15:0]   io_wd,
  output logic [15:0]   io_rdata,
  output logic          busy,
  output logic [AW-1:0] sram_a,
  output logic          sram_ncs,
  output logic          sram_nwe,
  output logic          sram_noe,
  output logic [DW-1:0] sram_dout,
  output logic          sram_doe,
  input  logic [DW-1:0] sram_din
);

  localparam logic [3:0] WR_LOAD = 4'(WAIT_CYCLES - 1);
  localparam logic [3:0] RD_LOAD = 4'(WAIT_CYCLES);

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d, sram_a_q, sram_a_d;
  logic [DW-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic          autoinc_q, autoinc_d, rvalid_q, rvalid_d, err_q, err_d;
  logic          busy_q, busy_d, ncs_q, ncs_d, nwe_q, nwe_d, noe_q, noe_d, doe_q, doe_d;
  logic          idle, start_wr, start_rd, err_set, err_clr;
  logic          tmr_load, tmr_dec, tmr_done;
  logic [3:0]    tmr_val;

  sram_wait_timer u_timer (
    .pclk     (pclk),
    .resetq   (resetq),
    .load     (tmr_load),
    .load_val (tmr_val),
    .dec      (tmr_dec),
    .done     (tmr_done)
  );

  assign idle = (state_q == S_IDLE);

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    autoinc_d = autoinc_q;
    rvalid_d  = rvalid_q;
    start_wr  = 1'b0;
    start_rd  = 1'b0;
    err_set   = 1'b0;
    err_clr   = 1'b0;
    tmr_load  = 1'b0;
    tmr_val   = 4'd0;
    tmr_dec   = 1'b0;

    // A write strobe takes precedence; a simultaneous read has no side effect.
    if (io_wr) begin
      case (io_sel)
        REG_ADDR_LO: if (idle) addr_d[15:0] = io_wd; else err_set = 1'b1;
        REG_ADDR_HI: if (idle) addr_d[AW-1:16] = io_wd[AW-17:0]; else err_set = 1'b1;
        REG_DATA: begin
          if (idle) begin
            wdata_d  = io_wd[DW-1:0];
            start_wr = 1'b1;
          end else begin
            err_set = 1'b1;
          end
        end
        default: begin
          autoinc_d = io_wd[CTRL_AUTOINC_BIT];
          err_clr   = io_wd[CTRL_CLRERR_BIT];
          if (io_wd[CTRL_READ_BIT]) begin
            if (idle) start_rd = 1'b1;
            else      err_set  = 1'b1;
          end
        end
      endcase
    end else if (io_rd && (io_sel == REG_DATA)) begin
      rvalid_d = 1'b0;
      if (autoinc_q && idle) start_rd = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (start_wr) begin
          state_d = S_W_SETUP;
        end else if (start_rd) begin
          state_d  = S_R_PULSE;
          tmr_load = 1'b1;
          tmr_val  = RD_LOAD;
        end
      end
      S_W_SETUP: begin
        state_d  = S_W_PULSE;
        tmr_load = 1'b1;
        tmr_val  = WR_LOAD;
      end
      S_W_PULSE: begin
        if (tmr_done) state_d = S_W_HOLD;
        else          tmr_dec = 1'b1;
      end
      S_W_HOLD: begin
        state_d = S_IDLE;
        if (autoinc_q) addr_d = addr_q + 1'b1;
      end
      S_R_PULSE: begin
        if (tmr_done) begin
          state_d  = S_R_DONE;
          rdata_d  = sram_din;
          rvalid_d = 1'b1;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      S_R_DONE: begin
        state_d = S_IDLE;
        if (autoinc_q) addr_d = addr_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    err_d = err_set ? 1'b1 : (err_clr ? 1'b0 : err_q);

    // Pin strobes are registered images of the next state, so they glitch-free
    // follow the sequencer and drop with the asynchronous reset.
    busy_d   = (state_d != S_IDLE);
    ncs_d    = (state_d == S_IDLE);
    nwe_d    = (state_d != S_W_PULSE);
    noe_d    = (state_d != S_R_PULSE);
    doe_d    = (state_d == S_W_SETUP) || (state_d == S_W_PULSE) || (state_d == S_W_HOLD);
    sram_a_d = idle ? addr_q : sram_a_q;
  end

  always_ff @(posedge pclk or negedge resetq) begin
    if (!resetq) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      autoinc_q <= 1'b0;
      rvalid_q  <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      ncs_q     <= 1'b1;
      nwe_q     <= 1'b1;
      noe_q     <= 1'b1;
      doe_q     <= 1'b0;
      sram_a_q  <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      autoinc_q <= autoinc_d;
      rvalid_q  <= rvalid_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
      ncs_q     <= ncs_d;
      nwe_q     <= nwe_d;
      noe_q     <= noe_d;
      doe_q     <= doe_d;
      sram_a_q  <= sram_a_d;
    end
  end

  always_comb begin
    io_rdata = 16'h0000;
    case (io_sel)
      REG_ADDR_LO: io_rdata = addr_q[15:0];
      REG_ADDR_HI: io_rdata = 16'(addr_q[AW-1:16]);
      REG_DATA:    io_rdata = 16'(rdata_q);
      default: begin
        io_rdata[STAT_BUSY_BIT]    = busy_q;
        io_rdata[STAT_RVALID_BIT]  = rvalid_q;
        io_rdata[STAT_AUTOINC_BIT] = autoinc_q;
        io_rdata[STAT_ERR_BIT]     = err_q;
      end
    endcase
  end

  assign busy      = busy_q;
  assign sram_a    = sram_a_q;
  assign sram_ncs  = ncs_q;
  assign sram_nwe  = nwe_q;
  assign sram_noe  = noe_q;
  assign sram_doe  = doe_q;
  assign sram_dout = wdata_q;

endmodule

// File: tb/tb_sram_bus_ctrl.sv
// Bench for sram_bus_ctrl: directed scenarios plus random register traffic checked
// against a transaction-level model and a pin-level SRAM access monitor.
module tb_sram_bus_ctrl;

  localparam int DW   = 8;
  localparam int AW   = 18;
  localparam int WAIT = 2;

  logic          pclk = 1'b0;
  logic          resetq;
  logic [1:0]    io_sel;
  logic          io_wr, io_rd;
  logic [15:0]   io_wd;
  logic [15:0]   io_rdata;
  logic          busy;
  logic [AW-1:0] sram_a;
  logic          sram_ncs, sram_nwe, sram_noe, sram_doe;
  logic [DW-1:0] sram_dout, sram_din;

  logic          din_force;
  logic [DW-1:0] din_val;

  int total = 0;
  int bad   = 0;

  sram_bus_ctrl #(.DW(DW), .AW(AW), .WAIT_CYCLES(WAIT)) dut (
    .pclk(pclk), .resetq(resetq), .io_sel(io_sel), .io_wr(io_wr), .io_rd(io_rd),
    .io_wd(io_wd), .io_rdata(io_rdata), .busy(busy), .sram_a(sram_a),
    .sram_ncs(sram_ncs), .sram_nwe(sram_nwe), .sram_noe(sram_noe),
    .sram_dout(sram_dout), .sram_doe(sram_doe), .sram_din(sram_din)
  );

  always #5 pclk = ~pclk;

  function automatic logic [DW-1:0] ref_din(input logic [AW-1:0] a);
    logic [31:0] x;
    x = 32'(a);
    return DW'((x * 32'd97) ^ (x >> 5) ^ 32'h3C);
  endfunction

  function automatic logic [DW-1:0] exp_din(input logic [AW-1:0] a);
    return din_force ? din_val : ref_din(a);
  endfunction

  assign sram_din = exp_din(sram_a);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Pin-level monitor: one record per nCS-low window.
  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    int            ncs_n, nwe_n, noe_n, doe_n;
    bit            a_moved;
  } acc_t;

  acc_t cur;
  acc_t evq[$];

  always @(negedge pclk) begin
    if (!resetq) begin
      cur = '{default: 0};
    end else begin
      chk("nwe_noe_both_low", 32'(!sram_nwe && !sram_noe), 0);
      chk("doe_during_read", 32'(sram_doe && !sram_noe), 0);
      if (!sram_ncs) begin
        if (cur.ncs_n == 0) cur.a = sram_a;
        else if (sram_a !== cur.a) cur.a_moved = 1'b1;
        cur.ncs_n++;
        if (!sram_nwe) begin cur.nwe_n++; cur.d = sram_dout; end
        if (!sram_noe) cur.noe_n++;
        if (sram_doe) cur.doe_n++;
      end else if (cur.ncs_n > 0) begin
        evq.push_back(cur);
        cur = '{default: 0};
      end
    end
  end

  // Transaction-level reference state.
  logic [AW-1:0] m_addr;
  logic          m_auto, m_err, m_rvalid;
  logic [DW-1:0] m_rdata;

  function automatic logic [15:0] m_status();
    return {12'h000, m_err, m_auto, m_rvalid, 1'b0};
  endfunction

  task automatic wr_reg(input logic [1:0] sel, input logic [15:0] v);
    @(negedge pclk);
    io_sel = sel; io_wd = v; io_wr = 1'b1;
    @(negedge pclk);
    io_wr = 1'b0;
  endtask

  task automatic rd_reg(input logic [1:0] sel, input logic strobe, output logic [15:0] v);
    @(negedge pclk);
    io_sel = sel; io_rd = strobe;
    #1 v = io_rdata;
    @(negedge pclk);
    io_rd = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      @(negedge pclk);
    end
    chk("busy_timeout", 32'(n < 100), 1);
    #1;
  endtask

  task automatic expect_acc(input string tag, input bit is_wr, input logic [AW-1:0] a,
                            input logic [DW-1:0] d);
    acc_t e;
    chk({tag, "_present"}, 32'(evq.size() != 0), 1);
    if (evq.size() != 0) begin
      e = evq.pop_front();
      chk({tag, "_addr"}, 32'(e.a), 32'(a));
      chk({tag, "_addr_stable"}, 32'(e.a_moved), 0);
      chk({tag, "_ncs_len"}, e.ncs_n, WAIT + 2);
      chk({tag, "_nwe_len"}, e.nwe_n, is_wr ? WAIT : 0);
      chk({tag, "_noe_len"}, e.noe_n, is_wr ? 0 : WAIT + 1);
      chk({tag, "_doe_len"}, e.doe_n, is_wr ? WAIT + 2 : 0);
      if (is_wr) chk({tag, "_data"}, 32'(e.d), 32'(d));
    end
  endtask

  task automatic set_addr(input logic [AW-1:0] a);
    wr_reg(2'd0, a[15:0]);
    wr_reg(2'd1, 16'(a >> 16));
    m_addr = a;
  endtask

  task automatic set_ctrl(input logic [15:0] v);
    wr_reg(2'd3, v);
    m_auto = v[0];
    if (v[3]) m_err = 1'b0;
  endtask

  task automatic do_write(input logic [DW-1:0] d);
    int n;
    wr_reg(2'd2, 16'(d));
    wait_idle(n);
    chk("wr_busy_len", n, WAIT + 2);
    expect_acc("wr", 1'b1, m_addr, d);
    m_addr = m_addr + AW'(m_auto);
  endtask

  task automatic finish_read(input string tag);
    int n;
    wait_idle(n);
    chk({tag, "_busy_len"}, n, WAIT + 2);
    expect_acc(tag, 1'b0, m_addr, '0);
    m_rdata  = exp_din(m_addr);
    m_rvalid = 1'b1;
    m_addr   = m_addr + AW'(m_auto);
  endtask

  task automatic do_read_ctrl();
    wr_reg(2'd3, {14'h0, 1'b1, m_auto});
    finish_read("rd");
  endtask

  task automatic rd_data();
    logic [15:0] v;
    rd_reg(2'd2, 1'b1, v);
    chk("data_rd", 32'(v), 32'(m_rdata));
    m_rvalid = 1'b0;
    if (m_auto) finish_read("prefetch");
  endtask

  task automatic chk_regs();
    logic [15:0] v;
    rd_reg(2'd3, 1'b0, v); chk("status", 32'(v), 32'(m_status()));
    rd_reg(2'd0, 1'b0, v); chk("addr_lo", 32'(v), 32'(m_addr[15:0]));
    rd_reg(2'd1, 1'b0, v); chk("addr_hi", 32'(v), 32'(16'(m_addr >> 16)));
  endtask

  task automatic busy_violation(input logic [DW-1:0] d, input logic [15:0] junk);
    int n;
    wr_reg(2'd2, 16'(d));
    wr_reg(junk[1] ? 2'd2 : 2'd0, junk);
    wait_idle(n);
    expect_acc("bv", 1'b1, m_addr, d);
    m_addr = m_addr + AW'(m_auto);
    m_err  = 1'b1;
    repeat (3) @(negedge pclk);
    #1 chk("bv_single_access", evq.size(), 0);
  endtask

  initial begin
    logic [15:0] v;
    int n;
    resetq = 1'b0; io_sel = 2'd0; io_wr = 1'b0; io_rd = 1'b0; io_wd = 16'h0;
    din_force = 1'b0; din_val = '0;
    m_addr = '0; m_auto = 1'b0; m_err = 1'b0; m_rvalid = 1'b0; m_rdata = '0;

    repeat (3) @(negedge pclk);
    chk("rst_ncs", 32'(sram_ncs), 1);
    chk("rst_nwe", 32'(sram_nwe), 1);
    chk("rst_noe", 32'(sram_noe), 1);
    chk("rst_doe", 32'(sram_doe), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_sram_a", 32'(sram_a), 0);
    chk("rst_dout", 32'(sram_dout), 0);
    for (int s = 0; s < 4; s++) begin
      io_sel = 2'(s);
      #1 chk("rst_reg", 32'(io_rdata), 0);
    end
    @(negedge pclk);
    #1 resetq = 1'b1;

    // Basic write.
    set_addr(18'h11234);
    repeat (2) @(negedge pclk);
    chk("sram_a_follows", 32'(sram_a), 32'h11234);
    do_write(8'hA5);
    chk_regs();

    // Basic read with rvalid handshake.
    din_force = 1'b1; din_val = 8'h5A;
    do_read_ctrl();
    rd_reg(2'd3, 1'b0, v); chk("status_rvalid", 32'(v), 32'h0002);
    rd_data();
    rd_reg(2'd3, 1'b0, v); chk("status_cleared", 32'(v), 32'h0000);
    din_force = 1'b0;

    // Auto-increment wrap.
    set_ctrl(16'h0001);
    set_addr(18'h3FFFF);
    do_write(8'h11);
    do_write(8'h22);
    chk_regs();
    chk("wrap_addr", 32'(m_addr), 32'h00001);

    // Prefetch stream.
    set_addr(18'h00010);
    do_read_ctrl();
    repeat (3) rd_data();
    chk("stream_end_addr", 32'(m_addr), 32'h00014);
    chk_regs();

    // Write while busy is dropped and flagged.
    set_ctrl(16'h0000);
    busy_violation(8'h3C, 16'h00C3);
    chk_regs();
    set_ctrl(16'h0008);
    chk_regs();

    // Asynchronous reset in the middle of a write pulse.
    set_addr(18'h2ABCD);
    wr_reg(2'd2, 16'h0077);
    n = 0;
    while (sram_nwe !== 1'b0 && n < 10) begin n++; @(negedge pclk); end
    chk("reach_w_pulse", 32'(n < 10), 1);
    #2 resetq = 1'b0;
    #1;
    chk("arst_ncs", 32'(sram_ncs), 1);
    chk("arst_nwe", 32'(sram_nwe), 1);
    chk("arst_doe", 32'(sram_doe), 0);
    chk("arst_busy", 32'(busy), 0);
    repeat (2) @(negedge pclk);
    #1 resetq = 1'b1;
    m_addr = '0; m_auto = 1'b0; m_err = 1'b0; m_rvalid = 1'b0; m_rdata = '0;
    evq.delete();
    repeat (10) @(negedge pclk);
    #1 chk("post_rst_quiet", evq.size(), 0);
    chk_regs();

    // Random register traffic.
    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 6))
        0: set_addr(($urandom_range(0, 3) == 0) ? ('1 - AW'($urandom_range(0, 2)))
                                                 : AW'($urandom));
        1: do_write(DW'($urandom));
        2: do_read_ctrl();
        3: rd_data();
        4: set_ctrl({12'h0, 1'($urandom), 2'b00, 1'($urandom)});
        5: chk_regs();
        default: busy_violation(DW'($urandom), 16'($urandom));
      endcase
      rd_reg(2'd3, 1'b0, v);
      chk("rand_status", 32'(v), 32'(m_status()));
    end
    chk_regs();
    #1 chk("no_stray_access", evq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sram_bus_ctrl.md
Name: sram_bus_ctrl

Overview:
- Hardware SRAM cycle engine that replaces CPU bit-banging of SRAM address, control and data pins.
- Sits on the j1a IO bus next to the UART and GPIO ports.
- The CPU loads an address, then writes or reads DATA; the block generates correctly timed nCS/nWE/nOE cycles with programmable wait states.
- Optional address auto-increment supports streaming block transfers.

Parameters:
- DW, 8: SRAM data width; 8 or 16 only.
- AW, 18: SRAM address width; 17..32.
- WAIT_CYCLES, 2: strobe-low cycles per access; 1..15.

Ports:
- pclk  in  1  clock
- resetq  in  1  asynchronous active-low reset
- io_sel  in  2  register select: 0 ADDR_LO, 1 ADDR_HI, 2 DATA, 3 CTRL/STATUS
- io_wr  in  1  register write strobe, one cycle
- io_rd  in  1  register read strobe, one cycle; used only for read side effects
- io_wd  in  16  write data
- io_rdata  out  16  combinational read mux of the register selected by io_sel
- busy  out  1  SRAM cycle in progress
- sram_a  out  AW  SRAM address
- sram_ncs, sram_nwe, sram_noe  out  1 each  active-low SRAM strobes
- sram_dout  out  DW  data driven to SRAM
- sram_doe  out  1  data pad output enable; the tristate SB_IO lives at top level
- sram_din  in  DW  data from pads, already registered at top level

Interface decision: reset resetq, asynchronous, active-low; clock pclk.

Behaviour:
- Reset values:
  - addr=0, wdata=0, rdata=0.
  - autoinc=0, rvalid=0, err=0, busy=0.
  - sram_ncs/nwe/noe=1, sram_doe=0, sram_a=0, sram_dout=0.
  - Reset mid-cycle aborts immediately; strobes deassert asynchronously and no address increment occurs.
- Register writes:
  - ADDR_LO loads addr[15:0].
  - ADDR_HI loads addr[AW-1:16]; unused io_wd bits are ignored.
  - DATA loads wdata (low DW bits) and starts a WRITE cycle.
  - CTRL:
    - bit0 sets autoinc.
    - bit1=1 starts a READ cycle.
    - bit3=1 clears err.
- Register reads (io_rdata):
  - ADDR_LO returns addr[15:0].
  - ADDR_HI returns addr[AW-1:16], zero-extended.
  - DATA returns rdata, zero-extended.
  - STATUS returns {12'b0, err, autoinc, rvalid, busy}.
  - io_rd on DATA clears rvalid. If autoinc=1 and the block is idle, it also starts a READ at the current addr (prefetch stream).
- Busy rule: any io_wr to ADDR_LO, ADDR_HI or DATA, or any cycle-starting request, while busy=1 is dropped and sets err (sticky). CTRL writes of bit0 and bit3 are always accepted.
- io_wr and io_rd in the same cycle: the write acts and the read side effect is suppressed.
- FSM states: IDLE, W_SETUP, W_PULSE, W_HOLD, R_PULSE, R_DONE. Every non-IDLE state drives busy=1.
- busy asserts on the cycle after the accepting strobe.
- Write sequence:
  - W_SETUP (1 cycle): ncs=0, doe=1, address and data valid.
  - W_PULSE (WAIT_CYCLES cycles): ncs=0, nwe=0.
  - W_HOLD (1 cycle): nwe=1, ncs=0, doe=1.
  - Then IDLE.
  - Total busy = WAIT_CYCLES+2 cycles.
- Read sequence:
  - R_PULSE (WAIT_CYCLES+1 cycles): ncs=0, noe=0, doe=0.
  - rdata captures sram_din on the last R_PULSE cycle.
  - R_DONE (1 cycle): strobes high, rvalid=1.
  - Then IDLE.
  - Total busy = WAIT_CYCLES+2 cycles.
- sram_nwe and sram_noe are never low simultaneously. sram_doe=1 only in write states.
- Wait counter: 4 bits, loaded with WAIT_CYCLES-1 (write) or WAIT_CYCLES (read), decremented to 0.
- Auto-increment: with autoinc=1, addr increments by 1 on the transition to IDLE at the end of every completed cycle. It wraps modulo 2^AW, so all-ones becomes 0. With autoinc=0, addr is unchanged.
- sram_a mirrors addr, registered; it changes only in IDLE.

Decomposition:
- Shared package: register index constants (REG_ADDR_LO..REG_CTRL), STATUS/CTRL bit positions, FSM state encoding.
- One natural sub-module, sram_wait_timer: the loadable down-counter with a done flag.

Test Plan:
- Write ADDR_LO=0x1234, ADDR_HI=0x0001, DATA=0x00A5 (DW=8, WAIT=2) -> sram_a=0x11234; ncs low 4 cycles, nwe low exactly 2 cycles; doe=1 for 4 cycles; sram_dout=0xA5; busy high 4 cycles; addr unchanged.
- CTRL=0x0002 with sram_din=0x5A held -> noe low 3 cycles; STATUS then reads 0x0002 (rvalid); DATA reads 0x005A; STATUS then reads 0x0000.
- CTRL=0x0001, addr=0x3FFFF, write DATA twice, polling busy between -> first write at 0x3FFFF, second at 0x00000, addr ends at 0x00001.
- Stream read: autoinc=1, addr=0x00010, CTRL=0x0003, then three DATA reads each after busy falls -> reads hit 0x10, 0x11, 0x12, 0x13 (prefetch) and return the matching sram_din values.
- DATA write while busy -> second write dropped (one nwe pulse only); STATUS bit3=1; CTRL=0x0008 clears it to 0.
- resetq low during W_PULSE -> nwe/ncs high and doe=0 within the same cycle; busy=0; addr=0; no further SRAM activity after release.
